// File: rtl/score_history_reader_pkg.sv
// Shared types and constants for the score history reader.
// Widths default to those of the game's register file.
package score_history_reader_pkg;

  localparam int DATA_W_DEF = 13;
  localparam int ADDR_W_DEF = 3;

  localparam logic [DATA_W_DEF-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SHOW = 2'd2
  } readerState;

endpackage

// File: rtl/dwell_tick_counter.sv
// Tick-enabled dwell counter for auto-advance in the score display.
// TermCount strobes on the enabled tick that completes DWELL ticks.
module dwell_tick_counter #(
  parameter int DWELL = 1000
) (
  input  logic Clock,
  input  logic CLRN,
  input  logic Clear,
  input  logic Enable,
  output logic TermCount
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  assign TermCount = Enable && (count == LAST);

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN)
      count <= '0;
    else if (Clear)
      count <= '0;
    else if (Enable)
      count <= TermCount ? '0 : count + CNT_W'(1);
  end

endmodule

// File: rtl/score_history_reader.sv
// Read-only client of the score register file: scans slots 1..n for
// best/worst/sum, then pages stored scores out to the display path.
//
// state | meaning
// IDLE  | waiting for Start; statistics cleared or empty
// SCAN  | walking ReadQ over slots 1..n, accumulating
// SHOW  | statistics valid, ShowIndex paged by Step or dwell
module score_history_reader
  import score_history_reader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_SLOTS = 7,
  parameter int SUM_W     = 16,
  parameter int DWELL     = 1000
) (
  input  logic              Clock,
  input  logic              CLRN,
  input  logic              Start,
  input  logic              Step,
  input  logic              Tick,
  input  logic              AutoEn,
  input  logic [DATA_W-1:0] RunCount,
  input  logic [DATA_W-1:0] DataQ,
  output logic [ADDR_W-1:0] ReadQ,
  output logic              Busy,
  output logic              Done,
  output logic              Empty,
  output logic [DATA_W-1:0] BestScore,
  output logic [DATA_W-1:0] WorstScore,
  output logic [SUM_W-1:0]  ScoreSum,
  output logic [ADDR_W-1:0] ValidCount,
  output logic [ADDR_W-1:0] ShowIndex,
  output logic [DATA_W-1:0] ShowScore
);

  readerState state, stateNext;

  logic [ADDR_W-1:0] readQNext, countNext, showIdxNext, runN;
  logic [DATA_W-1:0] bestNext, worstNext, showScoreNext;
  logic [SUM_W-1:0]  sumNext;
  logic              busyNext, doneNext, emptyNext;
  logic              dwellClear, dwellEnable, dwellTc, advance;

  assign runN = (RunCount > DATA_W'(NUM_SLOTS)) ? ADDR_W'(NUM_SLOTS)
                                                : RunCount[ADDR_W-1:0];

  assign dwellEnable = (state == SHOW) && AutoEn && Tick;
  assign advance     = Step || dwellTc;

  dwell_tick_counter #(.DWELL(DWELL)) uDwell (
    .Clock     (Clock),
    .CLRN      (CLRN),
    .Clear     (dwellClear),
    .Enable    (dwellEnable),
    .TermCount (dwellTc)
  );

  always_comb begin
    stateNext     = state;
    readQNext     = ReadQ;
    busyNext      = Busy;
    doneNext      = Done;
    emptyNext     = Empty;
    bestNext      = BestScore;
    worstNext     = WorstScore;
    sumNext       = ScoreSum;
    countNext     = ValidCount;
    showIdxNext   = ShowIndex;
    showScoreNext = ShowScore;
    dwellClear    = 1'b0;

    case (state)
      SCAN: begin
        if (DataQ < BestScore)  bestNext  = DataQ;
        if (DataQ > WorstScore) worstNext = DataQ;
        sumNext = ScoreSum + SUM_W'(DataQ);
        if (ReadQ == ValidCount) begin
          busyNext    = 1'b0;
          doneNext    = 1'b1;
          showIdxNext = ADDR_W'(1);
          readQNext   = ADDR_W'(1);
          dwellClear  = 1'b1;
          stateNext   = SHOW;
        end else begin
          readQNext = ReadQ + ADDR_W'(1);
        end
      end
      default: begin
        if (state == SHOW) begin
          showScoreNext = DataQ;
          if (advance) begin
            showIdxNext = (ShowIndex >= ValidCount) ? ADDR_W'(1)
                                                    : ShowIndex + ADDR_W'(1);
            readQNext   = showIdxNext;
            dwellClear  = 1'b1;
          end
        end
        // Start overrides any display advance on the same edge.
        if (Start) begin
          busyNext  = (runN != '0);
          doneNext  = 1'b0;
          emptyNext = (runN == '0);
          bestNext  = SCORE_MAX;
          worstNext = '0;
          sumNext   = '0;
          countNext = runN;
          if (runN != '0) begin
            readQNext = ADDR_W'(1);
            stateNext = SCAN;
          end else begin
            stateNext = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      state      <= IDLE;
      ReadQ      <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Empty      <= 1'b0;
      BestScore  <= SCORE_MAX;
      WorstScore <= '0;
      ScoreSum   <= '0;
      ValidCount <= '0;
      ShowIndex  <= '0;
      ShowScore  <= '0;
    end else begin
      state      <= stateNext;
      ReadQ      <= readQNext;
      Busy       <= busyNext;
      Done       <= doneNext;
      Empty      <= emptyNext;
      BestScore  <= bestNext;
      WorstScore <= worstNext;
      ScoreSum   <= sumNext;
      ValidCount <= countNext;
      ShowIndex  <= showIdxNext;
      ShowScore  <= showScoreNext;
    end
  end

endmodule

// File: tb/tb_score_history_reader.sv
// Self-checking bench for score_history_reader: directed table, corner
// sequences, and randomized scans against a reference model of the slots.
module tb_score_history_reader;

  localparam int DW = 13;
  localparam int AW = 3;
  localparam int SW = 16;

  logic          Clock = 1'b0;
  logic          CLRN = 1'b0;
  logic          Start = 1'b0, Step = 1'b0, Tick = 1'b0, AutoEn = 1'b0;
  logic [DW-1:0] RunCount = '0;
  logic [DW-1:0] DataQ;
  logic [AW-1:0] ReadQ, ValidCount, ShowIndex;
  logic          Busy, Done, Empty;
  logic [DW-1:0] BestScore, WorstScore, ShowScore;
  logic [SW-1:0] ScoreSum;

  logic [DW-1:0] mem [0:7];

  int checks = 0;
  int fails  = 0;

  assign DataQ = mem[ReadQ];

  always #5 Clock = ~Clock;

  score_history_reader #(.DWELL(4)) dut (
    .Clock(Clock), .CLRN(CLRN), .Start(Start), .Step(Step), .Tick(Tick),
    .AutoEn(AutoEn), .RunCount(RunCount), .DataQ(DataQ), .ReadQ(ReadQ),
    .Busy(Busy), .Done(Done), .Empty(Empty), .BestScore(BestScore),
    .WorstScore(WorstScore), .ScoreSum(ScoreSum), .ValidCount(ValidCount),
    .ShowIndex(ShowIndex), .ShowScore(ShowScore)
  );

  typedef struct {
    int rc;
    int slot [7];
    int best;
    int worst;
    int sum;
    int n;
  } vecT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step1;
    @(posedge Clock);
    #1;
  endtask

  function automatic void refStats(input int n, output int best, output int worst, output int sum);
    best = 8191; worst = 0; sum = 0;
    for (int s = 1; s <= n; s++) begin
      if (int'(mem[s]) < best)  best  = int'(mem[s]);
      if (int'(mem[s]) > worst) worst = int'(mem[s]);
      sum += int'(mem[s]);
    end
  endfunction

  task automatic scanAndCheck(input int rc, input int eBest, input int eWorst,
                              input int eSum, input int eN);
    RunCount = DW'(rc);
    Start = 1'b1;
    step1;
    Start = 1'b0;
    if (eN == 0) begin
      chk("empty.Empty", 32'(Empty), 1);
      chk("empty.Busy", 32'(Busy), 0);
      chk("empty.Done", 32'(Done), 0);
      chk("empty.Best", 32'(BestScore), 8191);
      chk("empty.Worst", 32'(WorstScore), 0);
      chk("empty.Sum", 32'(ScoreSum), 0);
      chk("empty.ValidCount", 32'(ValidCount), 0);
      step1;
      step1;
      chk("empty.BusyLater", 32'(Busy), 0);
      chk("empty.DoneLater", 32'(Done), 0);
      return;
    end
    for (int k = 1; k <= eN; k++) begin
      chk("scan.ReadQ", 32'(ReadQ), 32'(k));
      chk("scan.Busy", 32'(Busy), 1);
      chk("scan.DoneLow", 32'(Done), 0);
      step1;
    end
    chk("scan.Done", 32'(Done), 1);
    chk("scan.BusyLow", 32'(Busy), 0);
    chk("scan.Empty", 32'(Empty), 0);
    chk("scan.Best", 32'(BestScore), 32'(eBest));
    chk("scan.Worst", 32'(WorstScore), 32'(eWorst));
    chk("scan.Sum", 32'(ScoreSum), 32'(eSum));
    chk("scan.ValidCount", 32'(ValidCount), 32'(eN));
    chk("scan.ShowIndex", 32'(ShowIndex), 1);
    step1;
    chk("scan.ShowScore", 32'(ShowScore), 32'(mem[1]));
  endtask

  task automatic pulse(input logic t, input logic s);
    Tick = t;
    Step = s;
    step1;
    Tick = 1'b0;
    Step = 1'b0;
  endtask

  vecT vecs [3];

  initial begin
    int b, w, sm, n, idx;

    vecs[0] = '{0, '{11, 22, 33, 44, 55, 66, 77}, 8191, 0, 0, 0};
    vecs[1] = '{9, '{100, 200, 300, 400, 500, 600, 700}, 100, 700, 2800, 7};
    vecs[2] = '{3, '{250, 180, 412, 5, 6, 7, 8}, 180, 412, 842, 3};

    mem[0] = '0;
    for (int s = 1; s < 8; s++) mem[s] = '0;

    // reset held with random stimulus
    for (int c = 0; c < 4; c++) begin
      Start = 1'($urandom); Step = 1'($urandom); Tick = 1'($urandom);
      AutoEn = 1'($urandom); RunCount = DW'($urandom_range(0, 8191));
      for (int s = 1; s < 8; s++) mem[s] = DW'($urandom_range(0, 8191));
      step1;
    end
    chk("rst.ReadQ", 32'(ReadQ), 0);
    chk("rst.Busy", 32'(Busy), 0);
    chk("rst.Done", 32'(Done), 0);
    chk("rst.Empty", 32'(Empty), 0);
    chk("rst.Best", 32'(BestScore), 8191);
    chk("rst.Worst", 32'(WorstScore), 0);
    chk("rst.Sum", 32'(ScoreSum), 0);
    chk("rst.ValidCount", 32'(ValidCount), 0);
    chk("rst.ShowIndex", 32'(ShowIndex), 0);
    chk("rst.ShowScore", 32'(ShowScore), 0);
    Start = 0; Step = 0; Tick = 0; AutoEn = 0; RunCount = '0;
    CLRN = 1'b1;
    step1;

    // directed table: empty, clamp, normal
    for (int v = 0; v < 3; v++) begin
      for (int s = 1; s < 8; s++) mem[s] = DW'(vecs[v].slot[s-1]);
      scanAndCheck(vecs[v].rc, vecs[v].best, vecs[v].worst, vecs[v].sum, vecs[v].n);
    end

    // Step paging with one-cycle ShowScore lag
    begin
      int expIdx [3] = '{2, 3, 1};
      int expSc  [3] = '{180, 412, 250};
      for (int i = 0; i < 3; i++) begin
        pulse(1'b0, 1'b1);
        chk("step.ShowIndex", 32'(ShowIndex), 32'(expIdx[i]));
        chk("step.ReadQ", 32'(ReadQ), 32'(expIdx[i]));
        step1;
        chk("step.ShowScore", 32'(ShowScore), 32'(expSc[i]));
      end
    end

    // auto-dwell: four ticks per advance
    AutoEn = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      pulse(1'b1, 1'b0);
      chk("dwell.hold", 32'(ShowIndex), 1);
    end
    pulse(1'b1, 1'b0);
    chk("dwell.advance", 32'(ShowIndex), 2);
    step1;
    chk("dwell.ShowScore", 32'(ShowScore), 180);
    for (int t = 1; t <= 3; t++) pulse(1'b1, 1'b0);
    chk("dwell.hold2", 32'(ShowIndex), 2);
    pulse(1'b1, 1'b1);
    chk("dwell.coincident", 32'(ShowIndex), 3);
    for (int t = 1; t <= 3; t++) pulse(1'b1, 1'b0);
    chk("dwell.afterCoincident", 32'(ShowIndex), 3);
    AutoEn = 1'b0;
    for (int t = 1; t <= 2; t++) pulse(1'b1, 1'b0);
    chk("dwell.autoOffHold", 32'(ShowIndex), 3);
    AutoEn = 1'b1;
    pulse(1'b1, 1'b0);
    chk("dwell.wrap", 32'(ShowIndex), 1);
    AutoEn = 1'b0;

    // Start while scanning is ignored; late RunCount change too
    RunCount = DW'(3);
    Start = 1'b1;
    step1;
    Start = 1'b0;
    chk("abort.ReadQ1", 32'(ReadQ), 1);
    step1;
    chk("abort.ReadQ2", 32'(ReadQ), 2);
    Start = 1'b1;
    RunCount = DW'(7);
    step1;
    Start = 1'b0;
    chk("abort.ReadQ3", 32'(ReadQ), 3);
    chk("abort.Busy", 32'(Busy), 1);
    step1;
    chk("abort.Done", 32'(Done), 1);
    chk("abort.Sum", 32'(ScoreSum), 842);
    chk("abort.Best", 32'(BestScore), 180);
    chk("abort.Worst", 32'(WorstScore), 412);
    chk("abort.ValidCount", 32'(ValidCount), 3);

    // CLRN mid-scan
    RunCount = DW'(3);
    Start = 1'b1;
    step1;
    Start = 1'b0;
    step1;
    chk("clrn.ReadQBefore", 32'(ReadQ), 2);
    CLRN = 1'b0;
    #2;
    chk("clrn.ReadQ", 32'(ReadQ), 0);
    chk("clrn.Busy", 32'(Busy), 0);
    chk("clrn.Done", 32'(Done), 0);
    chk("clrn.Best", 32'(BestScore), 8191);
    chk("clrn.Sum", 32'(ScoreSum), 0);
    chk("clrn.ValidCount", 32'(ValidCount), 0);
    chk("clrn.ShowIndex", 32'(ShowIndex), 0);
    step1;
    chk("clrn.NoResume", 32'(Busy), 0);
    CLRN = 1'b1;
    step1;
    scanAndCheck(3, 180, 412, 842, 3);

    // randomized scans and paging against the slot model
    for (int it = 0; it < 30; it++) begin
      int rc;
      for (int s = 1; s < 8; s++) begin
        case ($urandom_range(0, 7))
          0:       mem[s] = '0;
          1:       mem[s] = DW'(8191);
          default: mem[s] = DW'($urandom_range(0, 8191));
        endcase
      end
      rc = $urandom_range(1, 10);
      n = (rc > 7) ? 7 : rc;
      refStats(n, b, w, sm);
      scanAndCheck(rc, b, w, sm, n);
      idx = 1;
      repeat ($urandom_range(1, 6)) begin
        pulse(1'b0, 1'b1);
        idx = (idx == n) ? 1 : idx + 1;
        chk("rand.ShowIndex", 32'(ShowIndex), 32'(idx));
        step1;
        chk("rand.ShowScore", 32'(ShowScore), 32'(mem[idx]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
